// File: rtl/ps2_key_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ps2_key_rx_if                                              |
// | Brief    : Scan-code result bundle from the PS/2 receiver to the      |
// |            game control logic.                                        |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface ps2_key_rx_if;
   logic [15:0] xkey;
   logic        key_valid;
   logic        frame_err;
   logic [3:0]  key_hold;

   // Receiver side drives the results
   modport master (output xkey, key_valid, frame_err, key_hold);

   // Game logic side consumes them
   modport slave  (input  xkey, key_valid, frame_err, key_hold);
endinterface
`default_nettype wire

// File: rtl/ps2_key_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ps2_key_rx                                                 |
// | Brief    : PS/2 keyboard frame receiver. Synchronizes and filters the |
// |            PS/2 pins, decodes 11-bit frames, keeps the last two bytes |
// |            in xkey and flags parity/stop/timeout errors.              |
// |            Optional held-arrow tracking: define PS2_KEY_HOLD_EN.      |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module ps2_key_rx #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 10000
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   input  wire logic     ps2_clk,
   input  wire logic     ps2_data,
   ps2_key_rx_if.master  key_if
);

   localparam int c_fcnt_w = (FILTER_LEN  > 2) ? $clog2(FILTER_LEN)  : 1;
   localparam int c_tcnt_w = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [c_fcnt_w-1:0] c_fcnt_max = c_fcnt_w'(FILTER_LEN - 1);
   localparam logic [c_tcnt_w-1:0] c_tcnt_max = c_tcnt_w'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_clk_s1, r_clk_s2;
   logic                  r_dat_s1, r_dat_s2;
   logic                  r_filt;
   logic [c_fcnt_w-1:0]   r_fcnt;
   logic [c_tcnt_w-1:0]   r_tcnt;
   logic [7:0]            r_shreg;
   logic [2:0]            r_bit_cnt;
   logic                  r_par;
   logic [15:0]           r_xkey;
   logic                  r_key_valid;
   logic                  r_frame_err;
   logic                  w_flip;
   logic                  w_fall;
   logic                  w_tout;
   logic                  w_commit;
   logic                  w_err;

   // Two-stage synchronizers for both asynchronous PS/2 pins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clk_s1 <= 1'b0;
         r_clk_s2 <= 1'b0;
         r_dat_s1 <= 1'b0;
         r_dat_s2 <= 1'b0;
      end else begin
         r_clk_s1 <= ps2_clk;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= ps2_data;
         r_dat_s2 <= r_dat_s1;
      end
   end

   // The filtered level starts low, so a fall requires seeing the line high first
   assign w_flip = (r_clk_s2 != r_filt) && (r_fcnt == c_fcnt_max);
   assign w_fall = w_flip && r_filt;

   // Stability filter: flip only after FILTER_LEN consecutive differing samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_filt <= 1'b0;
         r_fcnt <= '0;
      end else if (r_clk_s2 == r_filt) begin
         r_fcnt <= '0;
      end else if (w_flip) begin
         r_filt <= r_clk_s2;
         r_fcnt <= '0;
      end else begin
         r_fcnt <= r_fcnt + 1'b1;
      end
   end

   // A fall event in the same cycle beats the timeout
   assign w_tout = (r_state != S_IDLE) && !w_fall && (r_tcnt == c_tcnt_max);

   // Mid-frame watchdog: held at zero in IDLE, cleared by every fall event
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tcnt <= '0;
      end else if ((r_state == S_IDLE) || w_fall || w_tout) begin
         r_tcnt <= '0;
      end else begin
         r_tcnt <= r_tcnt + 1'b1;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state plus commit/error decisions at the stop bit
   always_comb begin
      w_state_nxt = r_state;
      w_commit    = 1'b0;
      w_err       = 1'b0;
      if (w_tout) begin
         w_state_nxt = S_IDLE;
         w_err       = 1'b1;
      end else if (w_fall) begin
         case (r_state)
            S_IDLE:   if (!r_dat_s2) w_state_nxt = S_DATA;
            S_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
            S_PARITY: w_state_nxt = S_STOP;
            S_STOP: begin
               w_state_nxt = S_IDLE;
               if (r_dat_s2 && (^{r_shreg, r_par})) begin
                  w_commit = 1'b1;
               end else begin
                  w_err = 1'b1;
               end
            end
            default:  w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Frame datapath: LSB-first shift of data bits and parity capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shreg   <= '0;
         r_bit_cnt <= '0;
         r_par     <= 1'b0;
      end else if (w_fall) begin
         case (r_state)
            S_IDLE:   r_bit_cnt <= '0;
            S_DATA: begin
               r_shreg   <= {r_dat_s2, r_shreg[7:1]};
               r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            S_PARITY: r_par <= r_dat_s2;
            default:  ;
         endcase
      end
   end

   // Result registers: history update and one-cycle pulses, one clk after the stop sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_xkey      <= '0;
         r_key_valid <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_key_valid <= w_commit;
         r_frame_err <= w_err;
         if (w_commit) begin
            r_xkey <= {r_xkey[7:0], r_shreg};
         end
      end
   end

   assign key_if.xkey      = r_xkey;
   assign key_if.key_valid = r_key_valid;
   assign key_if.frame_err = r_frame_err;

`ifdef PS2_KEY_HOLD_EN
   logic       r_brk;
   logic       r_ext;
   logic [3:0] r_hold;

   // Held-arrow tracking; prefixes arm flags, the next real byte consumes them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_brk  <= 1'b0;
         r_ext  <= 1'b0;
         r_hold <= '0;
      end else if (w_err) begin
         r_brk <= 1'b0;
         r_ext <= 1'b0;
      end else if (w_commit) begin
         if (r_shreg == 8'hF0) begin
            r_brk <= 1'b1;
         end else if (r_shreg == 8'hE0) begin
            r_ext <= 1'b1;
         end else begin
            r_brk <= 1'b0;
            r_ext <= 1'b0;
            case (r_shreg)
               8'h6B:   r_hold[0] <= !r_brk;
               8'h74:   r_hold[1] <= !r_brk;
               8'h75:   r_hold[2] <= !r_brk;
               8'h72:   r_hold[3] <= !r_brk;
               default: ;
            endcase
         end
      end
   end

   assign key_if.key_hold = r_hold;
`else
   assign key_if.key_hold = 4'b0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ps2_key_rx                                              |
// | Brief    : Scoreboard bench for ps2_key_rx. Driver pushes expected    |
// |            pulses with their due cycle; a monitor pops and compares.  |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_ps2_key_rx;

   localparam int FILTER_LEN  = 8;
   localparam int TIMEOUT_CYC = 10000;
   localparam int H           = 50;   // PS/2 half period in clk cycles

   typedef struct {
      bit          is_err;
      logic [15:0] xkey;
      logic [3:0]  hold;
      int          at;
   } exp_t;

   logic clk      = 1'b0;
   logic rst_n    = 1'b0;
   logic ps2_clk  = 1'b1;
   logic ps2_data = 1'b1;
   int   cyc      = 0;
   int   errors   = 0;
   int   checks   = 0;

   exp_t        sbq[$];
   logic [15:0] m_xkey = '0;
   logic [3:0]  m_hold = '0;
   bit          m_brk  = 1'b0;

   ps2_key_rx_if kif ();

   ps2_key_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .key_if   (kif)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference behaviour of a committed byte
   task automatic model_commit(input logic [7:0] b);
      m_xkey = {m_xkey[7:0], b};
`ifdef PS2_KEY_HOLD_EN
      if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else if (b != 8'hE0) begin
         case (b)
            8'h6B:   m_hold[0] = !m_brk;
            8'h74:   m_hold[1] = !m_brk;
            8'h75:   m_hold[2] = !m_brk;
            8'h72:   m_hold[3] = !m_brk;
            default: ;
         endcase
         m_brk = 1'b0;
      end
`endif
   endtask

   // Drive the first nbits of a frame; full frames push their expected pulse
   task automatic send_bits(input logic [7:0] b, input bit flip_par, input int nbits,
                            input bit glitch, output int last_fall);
      logic [10:0] fr;
      exp_t        e;
      int          g;
      fr = {1'b1, (~^b) ^ flip_par, b, 1'b0};
      last_fall = 0;
      for (int i = 0; i < nbits; i++) begin
         g = 1 + (i % 3);
         ps2_data = fr[i];
         if (glitch) begin
            wait_cyc(10); ps2_clk = 1'b0; wait_cyc(g); ps2_clk = 1'b1; wait_cyc(H - 10 - g);
         end else begin
            wait_cyc(H);
         end
         ps2_clk   = 1'b0;
         last_fall = cyc;
         if (i == 10) begin
            e.at = cyc + 2 + FILTER_LEN;
            if (flip_par) begin
               e.is_err = 1'b1;
               m_brk    = 1'b0;
            end else begin
               e.is_err = 1'b0;
               model_commit(b);
            end
            e.xkey = m_xkey;
            e.hold = m_hold;
            sbq.push_back(e);
         end
         if (glitch) begin
            wait_cyc(20); ps2_clk = 1'b1; wait_cyc(g); ps2_clk = 1'b0; wait_cyc(H - 20 - g);
         end else begin
            wait_cyc(H);
         end
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic send(input logic [7:0] b);
      int lf;
      send_bits(b, 1'b0, 11, 1'b0, lf);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      wait_cyc(3);
      m_xkey = '0;
      m_hold = '0;
      m_brk  = 1'b0;
      rst_n  = 1'b1;
      wait_cyc(20);
   endtask

   // Monitor: every output pulse must match the head of the scoreboard
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n && (kif.key_valid || kif.frame_err)) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: key_valid=%b frame_err=%b xkey=%h, nothing expected",
                     kif.key_valid, kif.frame_err, kif.xkey);
         end else begin
            e = sbq.pop_front();
            chk("pulse_kind", {30'd0, kif.frame_err, kif.key_valid}, e.is_err ? 32'd2 : 32'd1);
            if (!e.is_err) begin
               chk("pulse_xkey", {16'd0, kif.xkey}, {16'd0, e.xkey});
               chk("pulse_key_hold", {28'd0, kif.key_hold}, {28'd0, e.hold});
            end
            if (e.at >= 0) chk("pulse_cycle", cyc, e.at);
         end
      end
   end

   initial begin : watchdog
      #600000;
      errors++;
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int   lf;
      exp_t e;

      // Reset values
      wait_cyc(3);
      chk("reset_xkey",      {16'd0, kif.xkey},      32'h0);
      chk("reset_key_valid", {31'd0, kif.key_valid}, 32'h0);
      chk("reset_frame_err", {31'd0, kif.frame_err}, 32'h0);
      chk("reset_key_hold",  {28'd0, kif.key_hold},  32'h0);
      rst_n = 1'b1;
      wait_cyc(20);

      // Short low glitches in IDLE with data low must not start a frame
      for (int g = 1; g <= 3; g++) begin
         ps2_data = 1'b0;
         ps2_clk  = 1'b0; wait_cyc(g);
         ps2_clk  = 1'b1; wait_cyc(20);
      end
      ps2_data = 1'b1;
      wait_cyc(20);

      // Two 0x6B frames
      send(8'h6B);
      chk("xkey_after_6B", {16'd0, kif.xkey}, 32'h006B);
      send(8'h6B);
      chk("xkey_after_6B6B", {16'd0, kif.xkey}, 32'h6B6B);

      // Bad parity: one frame_err, history untouched
      send_bits(8'h75, 1'b1, 11, 1'b0, lf);
      chk("xkey_after_bad_parity", {16'd0, kif.xkey}, 32'h6B6B);

      // Start + 3 data bits, then silence until the watchdog fires
      send_bits(8'h5A, 1'b0, 4, 1'b0, lf);
      e.is_err = 1'b1; e.xkey = m_xkey; e.hold = m_hold;
      e.at = lf + 2 + FILTER_LEN + TIMEOUT_CYC;
      m_brk = 1'b0;
      sbq.push_back(e);
      wait_cyc(TIMEOUT_CYC + 100);
      chk("timeout_pulse_seen", sbq.size(), 32'd0);
      chk("xkey_after_timeout", {16'd0, kif.xkey}, 32'h6B6B);
      send(8'h74);
      chk("xkey_low_after_timeout", {24'd0, kif.xkey[7:0]}, 32'h74);

      // Glitched PS/2 clock in both phases of every bit
      send_bits(8'h72, 1'b0, 11, 1'b1, lf);
      chk("xkey_after_glitch_72", {16'd0, kif.xkey}, 32'h7472);

      // Reset after 5 data bits, then a clean frame
      send_bits(8'h33, 1'b0, 6, 1'b0, lf);
      rst_n = 1'b0;
      wait_cyc(2);
      chk("midrst_xkey",      {16'd0, kif.xkey},      32'h0);
      chk("midrst_key_valid", {31'd0, kif.key_valid}, 32'h0);
      chk("midrst_frame_err", {31'd0, kif.frame_err}, 32'h0);
      chk("midrst_key_hold",  {28'd0, kif.key_hold},  32'h0);
      m_xkey = '0; m_hold = '0; m_brk = 1'b0;
      rst_n = 1'b1;
      wait_cyc(5);
      send(8'h6B);
      chk("xkey_after_reset_6B", {16'd0, kif.xkey}, 32'h006B);

      // Arrow hold tracking: E0 75 press, then E0 F0 75 release
      do_reset();
      send(8'hE0);
      send(8'h75);
`ifdef PS2_KEY_HOLD_EN
      chk("hold_after_up_press", {28'd0, kif.key_hold}, 32'h4);
`else
      chk("hold_after_up_press", {28'd0, kif.key_hold}, 32'h0);
`endif
      send(8'hE0);
      send(8'hF0);
      send(8'h75);
      chk("hold_after_up_break", {28'd0, kif.key_hold}, 32'h0);
      chk("xkey_after_break", {16'd0, kif.xkey}, 32'hF075);

      wait_cyc(50);
      chk("scoreboard_drained", sbq.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
